// File: rtl/mag_comparator_pipe_if.sv
// Operand/result handshake bundle for mag_comparator_pipe.
// The master side drives operands and consumes results; the slave side is the comparator.
interface mag_comparator_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             a_equal_b;
  logic             a_less_b;
  logic             a_greater_b;
  logic             cnt_clr;
  logic [CNT_W-1:0] eq_count;
  logic [CNT_W-1:0] lt_count;
  logic [CNT_W-1:0] gt_count;

  modport master (
    output in_valid, a, b, signed_mode, out_ready, cnt_clr,
    input  in_ready, out_valid, a_equal_b, a_less_b, a_greater_b,
           eq_count, lt_count, gt_count
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready, cnt_clr,
    output in_ready, out_valid, a_equal_b, a_less_b, a_greater_b,
           eq_count, lt_count, gt_count
  );
endinterface

// File: rtl/mag_comparator_pipe.sv
// Single-stage registered magnitude comparator (unsigned / two's complement) with
// valid/ready handshake and saturating per-result event counters.
module mag_comparator_pipe #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mag_comparator_pipe_if.slave bus
);

  // Result encoding is {greater, less, equal}; exactly one bit set per result.
  // Signed compare: inverting both sign bits maps two's complement order onto unsigned order.
  function automatic logic [2:0] compare(input logic [WIDTH-1:0] op_a,
                                         input logic [WIDTH-1:0] op_b,
                                         input logic             sgn);
    logic [WIDTH-1:0] ka;
    logic [WIDTH-1:0] kb;
    ka = op_a;
    kb = op_b;
    if (sgn) begin
      ka[WIDTH-1] = ~op_a[WIDTH-1];
      kb[WIDTH-1] = ~op_b[WIDTH-1];
    end else begin
      ka = op_a;
    end
    if (ka == kb) begin
      compare = 3'b001;
    end else if (ka < kb) begin
      compare = 3'b010;
    end else begin
      compare = 3'b100;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             hit);
    if (hit && (cnt != {CNT_W{1'b1}})) begin
      sat_inc = cnt + CNT_W'(1'b1);
    end else begin
      sat_inc = cnt;
    end
  endfunction

  logic             valid_q, valid_d;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             drain_s;
  logic             sgn_s;
  logic [2:0]       cmp_s;

  assign in_ready_s = !valid_q || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign drain_s    = valid_q && bus.out_ready;
  assign sgn_s      = (SIGNED_EN != 0) && bus.signed_mode;
  assign cmp_s      = compare(bus.a, bus.b, sgn_s);

  // Output stage next state: load on accept, clear on drain, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    flags_d = flags_q;
    if (accept_s) begin
      valid_d = 1'b1;
      flags_d = cmp_s;
    end else if (drain_s) begin
      valid_d = 1'b0;
      flags_d = 3'b000;
    end else begin
      valid_d = valid_q;
      flags_d = flags_q;
    end
  end

  // Counter next state: clear beats a coincident handshake.
  always_comb begin
    eq_cnt_d = eq_cnt_q;
    lt_cnt_d = lt_cnt_q;
    gt_cnt_d = gt_cnt_q;
    if (bus.cnt_clr) begin
      eq_cnt_d = '0;
      lt_cnt_d = '0;
      gt_cnt_d = '0;
    end else if (drain_s) begin
      eq_cnt_d = sat_inc(eq_cnt_q, flags_q[0]);
      lt_cnt_d = sat_inc(lt_cnt_q, flags_q[1]);
      gt_cnt_d = sat_inc(gt_cnt_q, flags_q[2]);
    end else begin
      eq_cnt_d = eq_cnt_q;
      lt_cnt_d = lt_cnt_q;
      gt_cnt_d = gt_cnt_q;
    end
  end

  // State registers; reset drops any held result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      flags_q  <= 3'b000;
      eq_cnt_q <= '0;
      lt_cnt_q <= '0;
      gt_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      flags_q  <= flags_d;
      eq_cnt_q <= eq_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      gt_cnt_q <= gt_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = valid_q;
  assign bus.a_equal_b   = flags_q[0];
  assign bus.a_less_b    = flags_q[1];
  assign bus.a_greater_b = flags_q[2];
  assign bus.eq_count    = eq_cnt_q;
  assign bus.lt_count    = lt_cnt_q;
  assign bus.gt_count    = gt_cnt_q;

endmodule
